// File: rtl/card_table_pkg.sv
// Shared constants, field slices and FSM encoding for the card table.
package card_table_pkg;

  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;
  localparam int DW    = 14;

  localparam int STATE_MSB = 13;
  localparam int STATE_LSB = 12;
  localparam int COLOR_MSB = 11;
  localparam int COLOR_LSB = 0;

  localparam logic [1:0] CARD_HIDDEN   = 2'b00;
  localparam logic [1:0] CARD_FACEUP   = 2'b01;
  localparam logic [1:0] CARD_MATCHED  = 2'b10;
  localparam logic [1:0] CARD_RESERVED = 2'b11;

  typedef logic [DW-1:0] entry_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   count_t;

  localparam addr_t  ADDR_ONE   = addr_t'(1);
  localparam addr_t  ADDR_LAST  = addr_t'(DEPTH - 1);
  localparam count_t COUNT_ONE  = count_t'(1);
  localparam count_t COUNT_FULL = count_t'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEARING = 2'b00,
    ST_LOADING  = 2'b01,
    ST_READY    = 2'b10
  } fsm_state_e;

  // A game-logic state write overrides the state bits of a same-cycle colour write.
  function automatic entry_t merge_entry(input entry_t cur, input logic wr_hit,
                                         input entry_t wr_data, input logic st_hit,
                                         input logic [1:0] st_value);
    entry_t nxt;
    if (wr_hit) nxt = wr_data;
    else        nxt = cur;
    if (st_hit) nxt[STATE_MSB:STATE_LSB] = st_value;
    return nxt;
  endfunction

endpackage

// File: rtl/card_table_if.sv
// Bus bundle between the colour/game/drawing stages (master) and the card table (slave).
interface card_table_if;
  import card_table_pkg::*;

  logic       clear;
  logic       wr_en;
  addr_t      wr_address;
  entry_t     wr_data;
  logic       wr_done;
  logic       st_we;
  addr_t      st_address;
  logic [1:0] st_value;
  addr_t      rd_address;
  entry_t     rd_data;
  logic       busy;
  logic       ready;
  count_t     write_count;
  logic       overflow;

  modport master (
    output clear, wr_en, wr_address, wr_data, wr_done,
    output st_we, st_address, st_value, rd_address,
    input  rd_data, busy, ready, write_count, overflow
  );

  modport slave (
    input  clear, wr_en, wr_address, wr_data, wr_done,
    input  st_we, st_address, st_value, rd_address,
    output rd_data, busy, ready, write_count, overflow
  );

endinterface

// File: rtl/card_table.sv
// Card colour/state table: sweeps itself clear, accepts a load, then serves
// registered reads to the drawing stage while game logic edits state fields.
module card_table
  import card_table_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  card_table_if.slave bus
);

  fsm_state_e state_q, state_d;
  addr_t      ptr_q, ptr_d;
  count_t     count_q, count_d;
  logic       overflow_q, overflow_d;
  entry_t     rd_data_q;
  logic       wr_accept_s;
  logic       st_accept_s;
  logic       sweep_s;

  logic [DW-1:0] mem [0:DEPTH-1];

  assign sweep_s = (state_q == ST_CLEARING);

  // Next-state and counter logic; a clear still lets same-cycle writes land.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    wr_accept_s = 1'b0;
    st_accept_s = 1'b0;
    case (state_q)
      ST_CLEARING: begin
        ptr_d = ptr_q + ADDR_ONE;
        if (ptr_q == ADDR_LAST) state_d = ST_LOADING;
        else                    state_d = ST_CLEARING;
      end
      ST_LOADING: begin
        wr_accept_s = bus.wr_en;
        st_accept_s = bus.st_we;
        if (bus.clear) begin
          state_d    = ST_CLEARING;
          ptr_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          if (bus.wr_en) begin
            if (count_q == COUNT_FULL) overflow_d = 1'b1;
            else                       count_d    = count_q + COUNT_ONE;
          end else begin
            count_d = count_q;
          end
          if (bus.wr_done) state_d = ST_READY;
          else             state_d = ST_LOADING;
        end
      end
      ST_READY: begin
        st_accept_s = bus.st_we;
        if (bus.clear) begin
          state_d    = ST_CLEARING;
          ptr_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (bus.wr_en && (count_q == COUNT_FULL)) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
      end
      default: begin
        state_d = ST_CLEARING;
        ptr_d   = '0;
      end
    endcase
  end

  // FSM, counters and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEARING;
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= mem[bus.rd_address];
    end
  end

  // Entry storage: the sweep owns the table while clearing, the write ports otherwise.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sweep_s && (ptr_q == addr_t'(i))) begin
        mem[i] <= '0;
      end else begin
        mem[i] <= merge_entry(mem[i],
                              wr_accept_s && (bus.wr_address == addr_t'(i)), bus.wr_data,
                              st_accept_s && (bus.st_address == addr_t'(i)), bus.st_value);
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = (state_q == ST_CLEARING);
  assign bus.ready       = (state_q == ST_READY);
  assign bus.write_count = count_q;
  assign bus.overflow    = overflow_q;

endmodule
